// File: rtl/alu_selftest_seq.sv
// Self-test sequencer for the ALU: walks an external vector table, drives the ALU,
// waits a settle time, compares the result/flags and reports pass/fail statistics.
module alu_selftest_seq #(
    parameter int                DATA_W    = 16,
    parameter int                OP_W      = 8,
    parameter int                FLAG_W    = 5,
    parameter int                NUM_VEC   = 16,
    parameter int                IDX_W     = 4,
    parameter int                SETTLE    = 2,
    parameter int                ERR_W     = 8,
    parameter logic [FLAG_W-1:0] FLAG_MASK = {FLAG_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              halt_on_fail_i,
    output logic [IDX_W-1:0]  vec_idx_o,
    input  logic [DATA_W-1:0] vec_a_i,
    input  logic [DATA_W-1:0] vec_b_i,
    input  logic [OP_W-1:0]   vec_op_i,
    input  logic [DATA_W-1:0] vec_c_exp_i,
    input  logic [FLAG_W-1:0] vec_flags_exp_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [OP_W-1:0]   alu_op_o,
    input  logic [DATA_W-1:0] alu_c_i,
    input  logic [FLAG_W-1:0] alu_flags_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [IDX_W-1:0]  fail_idx_o,
    output logic [DATA_W-1:0] fail_c_o,
    output logic [FLAG_W-1:0] fail_flags_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_FAIL   = 3'd6;

    localparam int               CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    function automatic logic vec_mismatch(
        input logic [DATA_W-1:0] c,
        input logic [DATA_W-1:0] c_exp,
        input logic [FLAG_W-1:0] f,
        input logic [FLAG_W-1:0] f_exp
    );
        return (c != c_exp) || ((f & FLAG_MASK) != (f_exp & FLAG_MASK));
    endfunction

    logic [2:0]        state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [IDX_W-1:0]  vec_idx_q,    vec_idx_d;
    logic [DATA_W-1:0] alu_a_q,      alu_a_d;
    logic [DATA_W-1:0] alu_b_q,      alu_b_d;
    logic [OP_W-1:0]   alu_op_q,     alu_op_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              pass_q,       pass_d;
    logic [ERR_W-1:0]  err_q,        err_d;
    logic              first_q,      first_d;
    logic [IDX_W-1:0]  fail_idx_q,   fail_idx_d;
    logic [DATA_W-1:0] fail_c_q,     fail_c_d;
    logic [FLAG_W-1:0] fail_flags_q, fail_flags_d;
    logic              mismatch_s;

    // Next-state and datapath decode for the sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vec_idx_d    = vec_idx_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        err_d        = err_q;
        first_d      = first_q;
        fail_idx_d   = fail_idx_q;
        fail_c_d     = fail_c_q;
        fail_flags_d = fail_flags_q;
        mismatch_s   = vec_mismatch(alu_c_i, vec_c_exp_i, alu_flags_i, vec_flags_exp_i);

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) begin
                    state_d      = S_APPLY;
                    vec_idx_d    = '0;
                    err_d        = '0;
                    first_d      = 1'b0;
                    fail_idx_d   = '0;
                    fail_c_d     = '0;
                    fail_flags_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_APPLY: begin
                alu_a_d  = vec_a_i;
                alu_b_d  = vec_b_i;
                alu_op_d = vec_op_i;
                cnt_d    = SETTLE_LD;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (mismatch_s) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end else begin
                        err_d = err_q;
                    end
                    // Only the first failing vector of a run is captured
                    if (!first_q) begin
                        first_d      = 1'b1;
                        fail_idx_d   = vec_idx_q;
                        fail_c_d     = alu_c_i;
                        fail_flags_d = alu_flags_i;
                    end else begin
                        first_d = first_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (mismatch_s && halt_on_fail_i) begin
                    state_d = S_FAIL;
                end else if (vec_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                vec_idx_d = vec_idx_q + IDX_W'(1);
                state_d   = S_APPLY;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_APPLY, S_SETTLE, S_CHECK, S_NEXT: begin
                busy_d = 1'b1;
                done_d = 1'b0;
                pass_d = 1'b0;
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_d == '0);
            end
            S_FAIL: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                pass_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            vec_idx_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_q      <= 1'b0;
            fail_idx_q   <= '0;
            fail_c_q     <= '0;
            fail_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vec_idx_q    <= vec_idx_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            first_q      <= first_d;
            fail_idx_q   <= fail_idx_d;
            fail_c_q     <= fail_c_d;
            fail_flags_q <= fail_flags_d;
        end
    end

    assign vec_idx_o    = vec_idx_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_op_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_count_o  = err_q;
    assign fail_idx_o   = fail_idx_q;
    assign fail_c_o     = fail_c_q;
    assign fail_flags_o = fail_flags_q;

endmodule

// File: tb/tb_alu_selftest_seq.sv
// Bench for alu_selftest_seq: three instances (default, relaxed flag mask, 3-bit error
// counter) share one vector table; a run-level model checks the default instance every cycle.
module tb_alu_selftest_seq;

    logic clk;
    logic reset;
    logic start;
    logic halt;

    logic [15:0] tab_a [16];
    logic [15:0] tab_b [16];
    logic [7:0]  tab_op[16];
    logic [15:0] tab_c [16];
    logic [4:0]  tab_f [16];

    int n_chk = 0;
    int n_err = 0;
    int edge_cnt = 0;
    bit chk_en = 1'b0;

    // Reference ALU: 05 add, 06 sub, 07 and, others xor; flags {0,0,neg,carry,zero}
    function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
        logic [16:0] r;
        case (op)
            8'h05:   r = {1'b0, a} + {1'b0, b};
            8'h06:   r = {1'b0, a} - {1'b0, b};
            8'h07:   r = {1'b0, a & b};
            default: r = {1'b0, a ^ b};
        endcase
        return {2'b00, r[15], r[16], (r[15:0] == 16'h0000), r[15:0]};
    endfunction

    // ---------------- DUT 0 : default parameters ----------------
    logic [3:0]  idx0, fidx0;
    logic [15:0] a0, b0, c0, fc0;
    logic [7:0]  op0, err0;
    logic [4:0]  f0, ff0;
    logic        busy0, done0, pass0;
    assign {f0, c0} = alu_fn(a0, b0, op0);

    alu_selftest_seq dut0 (
        .clk(clk), .reset(reset), .start_i(start), .halt_on_fail_i(halt),
        .vec_idx_o(idx0), .vec_a_i(tab_a[idx0]), .vec_b_i(tab_b[idx0]), .vec_op_i(tab_op[idx0]),
        .vec_c_exp_i(tab_c[idx0]), .vec_flags_exp_i(tab_f[idx0]),
        .alu_a_o(a0), .alu_b_o(b0), .alu_op_o(op0), .alu_c_i(c0), .alu_flags_i(f0),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_count_o(err0),
        .fail_idx_o(fidx0), .fail_c_o(fc0), .fail_flags_o(ff0)
    );

    // ---------------- DUT 1 : flag bit 2 excluded from compare ----------------
    logic [3:0]  idx1, fidx1;
    logic [15:0] a1, b1, c1, fc1;
    logic [7:0]  op1, err1;
    logic [4:0]  f1, ff1;
    logic        busy1, done1, pass1;
    assign {f1, c1} = alu_fn(a1, b1, op1);

    alu_selftest_seq #(.FLAG_MASK(5'b11011)) dut1 (
        .clk(clk), .reset(reset), .start_i(start), .halt_on_fail_i(halt),
        .vec_idx_o(idx1), .vec_a_i(tab_a[idx1]), .vec_b_i(tab_b[idx1]), .vec_op_i(tab_op[idx1]),
        .vec_c_exp_i(tab_c[idx1]), .vec_flags_exp_i(tab_f[idx1]),
        .alu_a_o(a1), .alu_b_o(b1), .alu_op_o(op1), .alu_c_i(c1), .alu_flags_i(f1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
        .fail_idx_o(fidx1), .fail_c_o(fc1), .fail_flags_o(ff1)
    );

    // ---------------- DUT 2 : 3-bit error counter ----------------
    logic [3:0]  idx2, fidx2;
    logic [15:0] a2, b2, c2, fc2;
    logic [7:0]  op2;
    logic [2:0]  err2;
    logic [4:0]  f2, ff2;
    logic        busy2, done2, pass2;
    assign {f2, c2} = alu_fn(a2, b2, op2);

    alu_selftest_seq #(.ERR_W(3)) dut2 (
        .clk(clk), .reset(reset), .start_i(start), .halt_on_fail_i(halt),
        .vec_idx_o(idx2), .vec_a_i(tab_a[idx2]), .vec_b_i(tab_b[idx2]), .vec_op_i(tab_op[idx2]),
        .vec_c_exp_i(tab_c[idx2]), .vec_flags_exp_i(tab_f[idx2]),
        .alu_a_o(a2), .alu_b_o(b2), .alu_op_o(op2), .alu_c_i(c2), .alu_flags_i(f2),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
        .fail_idx_o(fidx2), .fail_c_o(fc2), .fail_flags_o(ff2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- run-level model of DUT 0 ----------------
    // A run is a timeline: vector k occupies edges 5k..5k+4 after the start edge
    // (apply, settle x2, check, next); the check result lands on edge 5k+4.
    bit          m_run;
    int          m_t;
    logic [3:0]  m_idx, m_fidx;
    logic [15:0] m_a, m_b, m_fc;
    logic [7:0]  m_op;
    logic [4:0]  m_ff;
    int          m_err;
    bit          m_first, m_busy, m_done, m_pass;

    task automatic model_step();
        int k;
        int ph;
        logic [20:0] r;
        bit mis;
        if (!reset) begin
            m_run = 1'b0; m_idx = '0; m_a = '0; m_b = '0; m_op = '0;
            m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_err = 0; m_first = 1'b0;
            m_fidx = '0; m_fc = '0; m_ff = '0;
        end else begin
            if (m_run) begin
                m_t++;
            end else if (start) begin
                m_run = 1'b1; m_t = 0; m_err = 0; m_first = 1'b0;
                m_fidx = '0; m_fc = '0; m_ff = '0; m_done = 1'b0; m_pass = 1'b0;
            end
            if (m_run) begin
                k = m_t / 5;
                ph = m_t % 5;
                m_idx = 4'(k);
                m_busy = 1'b1;
                if (ph == 1) begin
                    m_a = tab_a[k]; m_b = tab_b[k]; m_op = tab_op[k];
                end
                if (ph == 4) begin
                    r = alu_fn(m_a, m_b, m_op);
                    mis = (r[15:0] != tab_c[k]) || (r[20:16] != tab_f[k]);
                    if (mis) begin
                        if (m_err < 255) m_err++;
                        if (!m_first) begin
                            m_first = 1'b1; m_fidx = 4'(k); m_fc = r[15:0]; m_ff = r[20:16];
                        end
                    end
                    if ((mis && halt) || k == 15) begin
                        m_run = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                        m_pass = !(mis && halt) && (m_err == 0);
                    end
                end
            end
        end
    endtask

    // Single compare process: outputs at each falling edge against the model
    initial forever begin
        @(negedge clk);
        model_step();
        if (chk_en) begin
            chk("vec_idx", 32'(idx0), 32'(m_idx));
            chk("alu_a", 32'(a0), 32'(m_a));
            chk("alu_b", 32'(b0), 32'(m_b));
            chk("alu_op", 32'(op0), 32'(m_op));
            chk("busy", 32'(busy0), 32'(m_busy));
            chk("done", 32'(done0), 32'(m_done));
            chk("pass", 32'(pass0), 32'(m_pass));
            chk("err_count", 32'(err0), 32'(m_err));
            chk("fail_idx", 32'(fidx0), 32'(m_fidx));
            chk("fail_c", 32'(fc0), 32'(m_fc));
            chk("fail_flags", 32'(ff0), 32'(m_ff));
        end
    end

    // ---------------- stimulus ----------------
    int s_edge;

    task automatic pulse_start();
        @(negedge clk);
        #2 start = 1'b1;
        s_edge = edge_cnt + 1;
        @(negedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_edges);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_edges"}, 32'(edge_cnt - s_edge + 1), 32'(exp_edges));
        #2;
    endtask

    task automatic build_table();
        logic [20:0] r;
        for (int i = 0; i < 16; i++) begin
            tab_a[i] = 16'($urandom);
            tab_b[i] = 16'($urandom);
            tab_op[i] = 8'(8'h05 + 8'($urandom_range(0, 3)));
        end
        tab_a[0] = 16'h0003; tab_b[0] = 16'h0004; tab_op[0] = 8'h05;
        tab_a[5] = 16'h1200; tab_b[5] = 16'h0035; tab_op[5] = 8'h05;
        for (int i = 0; i < 16; i++) begin
            r = alu_fn(tab_a[i], tab_b[i], tab_op[i]);
            tab_c[i] = r[15:0];
            tab_f[i] = r[20:16];
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; halt = 1'b0;
        build_table();
        // model pins: hand-computed ALU results
        chk("model_vec0_c", 32'(tab_c[0]), 32'h0007);
        chk("model_vec0_f", 32'(tab_f[0]), 32'h0);
        chk("model_vec5_c", 32'(tab_c[5]), 32'h1235);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        #2 reset = 1'b1;

        // Run 1: all vectors match, start pulse while busy must be ignored
        pulse_start();
        repeat (18) @(negedge clk);
        #2 start = 1'b1;
        @(negedge clk);
        #2 start = 1'b0;
        wait_done("run1", 80);
        chk("run1_pass", 32'(pass0), 32'd1);
        chk("run1_err", 32'(err0), 32'd0);
        chk("run1_fidx", 32'(fidx0), 32'd0);
        chk("run1_pass_m11011", 32'(pass1), 32'd1);
        chk("run1_pass_e3", 32'(pass2), 32'd1);

        // Run 2: wrong expected C at vector 5, no halt
        tab_c[5] = 16'h1234;
        pulse_start();
        wait_done("run2", 80);
        chk("run2_pass", 32'(pass0), 32'd0);
        chk("run2_err", 32'(err0), 32'd1);
        chk("run2_fidx", 32'(fidx0), 32'd5);
        chk("run2_fc", 32'(fc0), 32'h1235);
        chk("run2_err_e3", 32'(err2), 32'd1);

        // Run 3: same fault, halt on first failure
        halt = 1'b1;
        pulse_start();
        wait_done("run3", 30);
        chk("run3_pass", 32'(pass0), 32'd0);
        chk("run3_idx", 32'(idx0), 32'd5);
        chk("run3_alu_a", 32'(a0), 32'h1200);
        chk("run3_alu_b", 32'(b0), 32'h0035);
        chk("run3_alu_op", 32'(op0), 32'h05);
        repeat (6) @(negedge clk);
        chk("run3_hold_done", 32'(done0), 32'd1);
        chk("run3_hold_idx", 32'(idx0), 32'd5);
        #2;

        // Run 4: flag-only mismatch on bit 2 at vector 9 (restart from FAIL)
        halt = 1'b0;
        tab_c[5] = 16'h1235;
        tab_f[9] = tab_f[9] ^ 5'b00100;
        pulse_start();
        wait_done("run4", 80);
        chk("run4_err_full", 32'(err0), 32'd1);
        chk("run4_fidx_full", 32'(fidx0), 32'd9);
        chk("run4_pass_m11011", 32'(pass1), 32'd1);
        chk("run4_err_m11011", 32'(err1), 32'd0);
        tab_f[9] = tab_f[9] ^ 5'b00100;

        // Run 5/6: every vector wrong; second run restarts from DONE
        for (int i = 0; i < 16; i++) tab_c[i] = tab_c[i] ^ 16'h0001;
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            wait_done("run5", 80);
            chk("run5_err", 32'(err0), 32'd16);
            chk("run5_fidx", 32'(fidx0), 32'd0);
            chk("run5_err_e3_sat", 32'(err2), 32'd7);
            chk("run5_fidx_e3", 32'(fidx2), 32'd0);
            chk("run5_pass_e3", 32'(pass2), 32'd0);
        end
        for (int i = 0; i < 16; i++) tab_c[i] = tab_c[i] ^ 16'h0001;

        // Reset during SETTLE
        pulse_start();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_alu_a", 32'(a0), 32'd0);
        chk("midrst_alu_op", 32'(op0), 32'd0);
        chk("midrst_idx", 32'(idx0), 32'd0);
        chk("midrst_err", 32'(err0), 32'd0);
        #2 reset = 1'b1;

        // Run after reset completes cleanly
        pulse_start();
        wait_done("run7", 80);
        chk("run7_pass", 32'(pass0), 32'd1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_selftest_seq.md
Name: alu_selftest_seq

Overview:
- Automatic stimulus/response sequencer for the ALU; the machine-driven counterpart of the switch/hex demo.
- Instead of a human entering A, B and Opcode and reading C, this block does the following for each vector:
  - fetches the vector (operands, opcode, expected result/flags) from an external vector table;
  - drives the ALU inputs and waits a settle time;
  - samples C and Flags and compares them with the expected values.
- Reports pass/fail, an error count and the first failing vector.
- Sits beside the ALU in board-level bring-up; its outputs feed LEDs and hex displays.

Parameters:
- DATA_W, 16, ALU operand/result width
- OP_W, 8, opcode width
- FLAG_W, 5, ALU flag vector width
- NUM_VEC, 16, number of vectors in table (>=1)
- IDX_W, 4, vec_idx width (2^IDX_W >= NUM_VEC)
- SETTLE, 2, cycles between driving the ALU and sampling its result (>=1)
- ERR_W, 8, error counter width
- FLAG_MASK, 5'b11111, flags bits included in the compare

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- start  in  1  single-cycle pulse; begins a run from IDLE/DONE/FAIL
- halt_on_fail  in  1  1 = stop at first mismatch
- vec_idx  out  IDX_W  current table index
- vec_a  in  DATA_W  table operand A at vec_idx (combinational lookup)
- vec_b  in  DATA_W  table operand B
- vec_op  in  OP_W  table opcode
- vec_c_exp  in  DATA_W  expected C
- vec_flags_exp  in  FLAG_W  expected Flags
- alu_a  out  DATA_W  registered drive to ALU A
- alu_b  out  DATA_W  registered drive to ALU B
- alu_op  out  OP_W  registered drive to ALU Opcode
- alu_c  in  DATA_W  ALU result
- alu_flags  in  FLAG_W  ALU flags
- busy  out  1  run in progress
- done  out  1  run finished (DONE or FAIL)
- pass  out  1  valid when done: no mismatches
- err_count  out  ERR_W  mismatch count, saturating
- fail_idx  out  IDX_W  index of first mismatch
- fail_c  out  DATA_W  alu_c captured at first mismatch
- fail_flags  out  FLAG_W  alu_flags captured at first mismatch

Behaviour:
- Reset (reset=0 at a clk edge, any state, including mid-run):
  - state=IDLE;
  - all outputs 0: vec_idx, alu_a/b/op, busy, done, pass, err_count, fail_idx, fail_c, fail_flags.
- States: IDLE, APPLY, SETTLE, CHECK, NEXT, DONE, FAIL.
- IDLE:
  - start=1 → APPLY.
  - On the same edge: vec_idx=0, err_count=0, fail_* cleared, first-error flag cleared.
- APPLY (1 cycle):
  - register alu_a<=vec_a, alu_b<=vec_b, alu_op<=vec_op;
  - load settle counter with SETTLE-1; → SETTLE.
- SETTLE:
  - counter decrements each cycle; at 0 → CHECK.
  - Lasts exactly SETTLE cycles.
- CHECK (1 cycle), mismatch condition: alu_c != vec_c_exp, OR (alu_flags & FLAG_MASK) != (vec_flags_exp & FLAG_MASK).
  - On mismatch:
    - err_count += 1, saturating at 2^ERR_W-1;
    - if this is the first mismatch of the run, capture fail_idx=vec_idx, fail_c=alu_c, fail_flags=alu_flags.
  - Next state:
    - mismatch and halt_on_fail=1 → FAIL;
    - else vec_idx==NUM_VEC-1 → DONE;
    - else → NEXT.
- NEXT (1 cycle): vec_idx+=1; → APPLY.
- DONE:
  - done=1; pass=1 iff err_count==0.
  - start=1 → restart exactly as from IDLE.
- FAIL:
  - done=1, pass=0.
  - start=1 → restart.
- busy=1 in APPLY, SETTLE, CHECK, NEXT; start is ignored while busy.
- alu_a/b/op hold their value outside APPLY.
- vec_idx is held constant from APPLY through CHECK; vec_* inputs must be stable for that window.
- Timing:
  - per-vector: SETTLE+3 cycles (the final vector omits NEXT);
  - start sampled at edge 0 → state DONE (done=1) after NUM_VEC*(SETTLE+3) edges. Defaults: 80 cycles.
- done/pass/err_count/fail_* stay stable in DONE/FAIL until restart or reset.

Test Plan:
- Bench ALU model = correct adder-style model, 16 vectors all matching (e.g. vec0 A=0x0003 B=0x0004 op=0x05 exp C=0x0007 flags=0) → done=1 at cycle 80, pass=1, err_count=0, fail_idx=0.
- Inject a wrong expected C at vec_idx=5 (exp 0x1234, ALU 0x1235), halt_on_fail=0 → run completes at cycle 80, pass=0, err_count=1, fail_idx=5, fail_c=0x1235.
- Same fault, halt_on_fail=1 → FAIL entered after CHECK of vec 5 (cycle 30), done=1, pass=0, vec_idx stays 5, alu_a/b/op hold vec5 values.
- Flag-only mismatch on bit 2 with FLAG_MASK=5'b11011 → ignored, pass=1; with FLAG_MASK=5'b11111 → err_count=1.
- All 16 vectors wrong, ERR_W=3 → err_count saturates at 7, fail_idx=0.
- start pulse while busy → ignored. reset=0 mid-SETTLE → next cycle IDLE with all outputs 0. start in DONE → counters cleared, rerun completes with identical results.
